serial_adder_sub: RTL

Multi-cycle, parametrised adder/subtractor that processes an operand pair BPC bits per clock, starting from the LSB.
- Replaces wide combinational ripple chains where area matters more than latency.
- Sits between a register-file/controller and any consumer that can tolerate a start/done handshake.
- Adds subtract mode, borrow/carry handling, signed overflow and a busy/done protocol.

---
 rtl/serial_adder_sub_pkg.sv | 20 ++
 rtl/serial_adder_sub_if.sv | 25 ++
 rtl/serial_adder_sub_fa_slice.sv | 28 ++
 rtl/serial_adder_sub.sv | 119 +++++++++++
 4 files changed

// File: rtl/serial_adder_sub_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM encoding and
// helpers that size the slice counter.
package serial_adder_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int slice_count(input int width, input int bpc);
        return width / bpc;
    endfunction

    // The counter is never narrower than one bit, even for a single slice.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_sub_if.sv
// Start/done handshake and operand/result bus of the serial adder/subtractor.
interface serial_adder_sub_if #(parameter int WIDTH = 8);

    logic             i_start;
    logic             i_sub;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_carry;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;
    logic             o_overflow;

    modport master (
        output i_start, i_sub, i_a, i_b, i_carry,
        input  o_busy, o_done, o_sum, o_carry, o_overflow
    );

    modport slave (
        input  i_start, i_sub, i_a, i_b, i_carry,
        output o_busy, o_done, o_sum, o_carry, o_overflow
    );

endinterface

// File: rtl/serial_adder_sub_fa_slice.sv
// Combinational BPC-bit ripple adder; also exposes the carry into its top bit
// so the caller can derive signed overflow.
module fa_slice #(
    parameter int BPC = 1
) (
    input  logic [BPC-1:0] a,
    input  logic [BPC-1:0] b,
    input  logic           cin,
    output logic [BPC-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    // Ripple through the slice, remembering the carry entering the last bit.
    always_comb begin
        logic carry_v;
        carry_v = cin;
        sum     = '0;
        c_msb   = cin;
        for (int i = 0; i < BPC; i++) begin
            c_msb   = carry_v;
            sum[i]  = a[i] ^ b[i] ^ carry_v;
            carry_v = (a[i] & b[i]) | (carry_v & (a[i] ^ b[i]));
        end
        cout = carry_v;
    end

endmodule

// File: rtl/serial_adder_sub.sv
// Multi-cycle adder/subtractor that consumes BPC operand bits per clock,
// LSB first, behind a start/busy/done handshake.
module serial_adder_sub
    import serial_adder_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    serial_adder_sub_if.slave  bus
);

    localparam int N  = slice_count(WIDTH, BPC);
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_SLICE = CW'(N - 1);

    if ((WIDTH < 1) || (BPC < 1) || ((WIDTH % BPC) != 0)) begin : g_bad_params
        $error("serial_adder_sub: BPC must be >= 1 and divide WIDTH exactly");
    end

    state_e           state_r;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] ss_r;
    logic [WIDTH-1:0] sum_r;
    logic [CW-1:0]    cnt_r;
    logic             c_r;
    logic             carry_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH-1:0] sb_load_s;
    logic             c_load_s;
    logic [WIDTH-1:0] ss_next_s;
    logic [BPC-1:0]   slice_sum_s;
    logic             slice_cout_s;
    logic             slice_cmsb_s;

    fa_slice #(.BPC(BPC)) u_slice (
        .a     (sa_r[BPC-1:0]),
        .b     (sb_r[BPC-1:0]),
        .cin   (c_r),
        .sum   (slice_sum_s),
        .cout  (slice_cout_s),
        .c_msb (slice_cmsb_s)
    );

    // Subtraction is A + ~B + ~borrow_in, so invert B and the incoming borrow.
    assign sb_load_s = bus.i_sub ? ~bus.i_b : bus.i_b;
    assign c_load_s  = bus.i_carry ^ bus.i_sub;
    assign ss_next_s = (ss_r >> BPC) | (WIDTH'(slice_sum_s) << (WIDTH - BPC));

    // Handshake FSM together with the operand, sum and result registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            sa_r    <= '0;
            sb_r    <= '0;
            ss_r    <= '0;
            sum_r   <= '0;
            cnt_r   <= '0;
            c_r     <= 1'b0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (bus.i_start) begin
                        sa_r    <= bus.i_a;
                        sb_r    <= sb_load_s;
                        c_r     <= c_load_s;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sa_r  <= sa_r >> BPC;
                    sb_r  <= sb_r >> BPC;
                    ss_r  <= ss_next_s;
                    c_r   <= slice_cout_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == LAST_SLICE) begin
                        sum_r   <= ss_next_s;
                        carry_r <= slice_cout_s;
                        ovf_r   <= slice_cmsb_s ^ slice_cout_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy     = busy_r;
    assign bus.o_done     = done_r;
    assign bus.o_sum      = sum_r;
    assign bus.o_carry    = carry_r;
    assign bus.o_overflow = ovf_r;

endmodule
